// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg: shared response codes, register map, FSM states and bench timing
package axi_lite_regbank_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int IDX_CORE_ID = 0;
  localparam int IDX_DATE = 1;
  localparam logic [7:0] ADDR_CORE_ID = 8'h00;
  localparam logic [7:0] ADDR_DATE = 8'h04;
  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  localparam int CLK_PERIOD = 10;
  localparam int RST_CYCLES = 4;
endpackage

// File: rtl/axi_lite_strb_merge.sv
// axi_lite_strb_merge: per-byte merge of old data and write data under a byte strobe
module axi_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);
  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
    assign merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_data[b*8 +: 8];
  end
endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave with read-only ID registers and byte-strobed RW registers
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_WIDTH-1:0] CORE_ID = 32'hCAFE_0001,
  parameter logic [DATA_WIDTH-1:0] DATE = 32'h2024_0101
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int DEPTH = 2**IW;
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic [IW-1:0] aw_idx_q, wr_idx, ar_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data, merged;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wr_strb;
  logic aw_hs, w_hs, ar_hs, wr_done, wr_ok, ar_ok;
  logic [DATA_WIDTH-1:0] rw_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank [DEPTH];
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign wr_idx = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_hs ? s_axi_wdata : wdata_q;
  assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;
  assign wr_ok = ({1'b0, wr_idx} < (IW+1)'(NUM_REGS)) && (wr_idx > IW'(IDX_DATE));
  assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];
  assign ar_ok = {1'b0, ar_idx} < (IW+1)'(NUM_REGS);

  axi_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data(rw_q[wr_idx]),
    .wdata(wr_data),
    .wstrb(wr_strb),
    .merged(merged)
  );

  // write and read FSM state registers
  always_ff @(posedge clk) begin
    wr_state <= rst ? WR_IDLE : wr_next;
    rd_state <= rst ? RD_IDLE : rd_next;
  end

  // write FSM: readies, bvalid and the edge where the second of AW/W lands
  always_comb begin
    wr_next = wr_state;
    wr_done = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        s_axi_awready = !rst;
        s_axi_wready = !rst;
        wr_done = s_axi_awvalid & s_axi_wvalid;
        wr_next = wr_done ? WR_RESP : s_axi_awvalid ? WR_HAVE_ADDR : s_axi_wvalid ? WR_HAVE_DATA : WR_IDLE;
      end
      WR_HAVE_ADDR: begin
        s_axi_wready = !rst;
        wr_done = s_axi_wvalid;
        wr_next = wr_done ? WR_RESP : WR_HAVE_ADDR;
      end
      WR_HAVE_DATA: begin
        s_axi_awready = !rst;
        wr_done = s_axi_awvalid;
        wr_next = wr_done ? WR_RESP : WR_HAVE_DATA;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        wr_next = s_axi_bready ? WR_IDLE : WR_RESP;
      end
    endcase
  end

  // read FSM: one outstanding read, held until rready
  always_comb begin
    s_axi_arready = !rst && rd_state == RD_IDLE;
    s_axi_rvalid = rd_state == RD_RESP;
    rd_next = rd_state == RD_IDLE ? (s_axi_arvalid ? RD_RESP : RD_IDLE) : (s_axi_rready ? RD_IDLE : RD_RESP);
  end

  // register map view: constants, RW storage, zeros above NUM_REGS
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      bank[i] = i == IDX_CORE_ID ? CORE_ID : i == IDX_DATE ? DATE : i < NUM_REGS ? rw_q[i] : '0;
    for (int i = 0; i < NUM_REGS; i++)
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = bank[i];
  end

  // write path: capture half-transactions, commit merged data, pulse and response
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      s_axi_bresp <= RESP_OKAY;
      wr_pulse_o <= '0;
      for (int i = 0; i < DEPTH; i++) rw_q[i] <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_done) s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      wr_pulse_o <= (wr_done && wr_ok) ? NUM_REGS'(1) << wr_idx : '0;
      for (int i = 0; i < DEPTH; i++)
        if (wr_done && wr_ok && wr_idx == IW'(i)) rw_q[i] <= merged;
    end
  end

  // read path: latch data and response on the AR handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rdata <= ar_ok ? bank[ar_idx] : '0;
      s_axi_rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: randomized AXI4-Lite traffic against a register-map model
module tb_axi_lite_regbank;
  import axi_lite_regbank_pkg::*;
  localparam int NR = 8;
  localparam logic [31:0] CID = 32'hCAFE_0001;
  localparam logic [31:0] DT = 32'h2024_0101;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [NR*32-1:0] regs;
  logic [NR-1:0] pulse;
  logic [31:0] model [NR];
  int n_vec = 0, n_err = 0;

  always #(CLK_PERIOD/2) clk = ~clk;

  axi_lite_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .NUM_REGS(NR), .CORE_ID(CID), .DATE(DT)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_o(regs), .wr_pulse_o(pulse)
  );

  task automatic chk(input string tag, input logic [NR*32-1:0] got, input logic [NR*32-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] exp_regs();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // mode 0: AW then W, 1: W then AW, 2: same cycle; bdly: cycles bready held low
  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, input int mode, input int bdly);
    int idx;
    logic ok;
    logic [31:0] m;
    logic [NR-1:0] ep;
    idx = int'(a[6:2]);
    ok = idx >= 2 && idx < NR;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ep = ok ? NR'(1) << idx : '0;
    @(negedge clk);
    chk("awready_idle", awready, 1);
    chk("wready_idle", wready, 1);
    if (mode != 1) begin awaddr = a; awvalid = 1'b1; end
    if (mode != 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
    if (mode != 2) begin
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b0;
      chk("half_bvalid", bvalid, 0);
      chk("half_awready", awready, mode == 1);
      chk("half_wready", wready, mode == 0);
      if (mode == 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      else begin awaddr = a; awvalid = 1'b1; end
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (ok) model[idx] = (model[idx] & ~m) | (d & m);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, ok ? RESP_OKAY : RESP_SLVERR);
    chk("regs", regs, exp_regs());
    chk("pulse", pulse, ep);
    for (int k = 0; k < bdly; k++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, ok ? RESP_OKAY : RESP_SLVERR);
      chk("awready_hold", awready, 0);
      chk("wready_hold", wready, 0);
      chk("pulse_once", pulse, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_done", bvalid, 0);
    chk("pulse_done", pulse, 0);
  endtask

  task automatic do_read(input logic [6:0] a, input int rdly);
    int idx;
    logic [31:0] e;
    idx = int'(a[6:2]);
    e = idx < NR ? model[idx] : 32'h0;
    @(negedge clk);
    chk("arready_idle", arready, 1);
    araddr = a;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, e);
    chk("rresp", rresp, idx < NR ? RESP_OKAY : RESP_SLVERR);
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, e);
      chk("arready_hold", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_done", rvalid, 0);
  endtask

  initial begin
    model[0] = CID;
    model[1] = DT;
    for (int i = 2; i < NR; i++) model[i] = '0;
    repeat (RST_CYCLES) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);
    chk("post_rst_valids", {bvalid, rvalid}, 2'b00);
    chk("post_rst_resp", {bresp, rresp, rdata}, 0);
    chk("post_rst_pulse", pulse, 0);
    chk("post_rst_regs", regs, exp_regs());
    do_read(7'h00, 0);
    do_read(7'h04, 0);
    do_write(7'h08, 32'hDEADBEEF, 4'b1111, 1, 0);
    do_read(7'h08, 0);
    do_write(7'h0C, 32'hFFFFFFFF, 4'b1111, 0, 0);
    do_write(7'h0C, 32'h11223344, 4'b0101, 2, 0);
    chk("partial_strobe", regs[3*32 +: 32], 32'hFF22FF44);
    do_write(7'h00, 32'h12345678, 4'b1111, 2, 0);
    do_write(7'h7C, 32'h12345678, 4'b1111, 0, 0);
    do_read(7'h7C, 0);
    do_write(7'h10, 32'h0, 4'b0000, 2, 5);
    do_read(7'h10, 5);
    do_write(7'h08, 32'h0, 4'b1111, 2, 0);
    @(negedge clk);
    araddr = 7'h08; arvalid = 1'b1;
    awaddr = 7'h08; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model[2] = 32'h5;
    chk("same_cycle_rdata", rdata, 32'h0);
    chk("same_cycle_valids", {rvalid, bvalid}, 2'b11);
    chk("same_cycle_regs", regs, exp_regs());
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("same_cycle_done", {rvalid, bvalid}, 2'b00);
    do_read(7'h08, 0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] a;
      a = {($urandom_range(0, 5) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    @(negedge clk);
    awaddr = 7'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    rst = 1'b1;
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
    rst = 1'b0;
    wvalid = 1'b0;
    for (int i = 2; i < NR; i++) model[i] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_regs", regs, exp_regs());
    end
    do_read(7'h0C, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

Parametrised AXI4-Lite slave register bank that generalises the fixed two-register (CORE_ID at 0x00, DATE at 0x04) example core into a bank of NUM_REGS word registers. It exposes read-only identification registers followed by byte-strobed read/write control registers. The bank sits between the AXI interconnect and the user datapath, which reads the RW registers through a flattened output bus and a per-register write pulse.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported (WSTRB_WIDTH = DATA_WIDTH/8 = 4).
- ADDR_WIDTH, 7, byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 8, number of registers; legal range 3..2^(ADDR_WIDTH-2), i.e. up to 32.
- CORE_ID, 32'hCAFE_0001, read-only value of register 0 (byte address 0x00).
- DATE, 32'h2024_0101, read-only value of register 1 (byte address 0x04).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
- regs_o  out  NUM_REGS*DATA_WIDTH  current value of every register; register i is at bits [i*32 +: 32].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse for each register written with OKAY.

## Operation
- Registers 0 and 1 are read-only constants (CORE_ID, DATE). Registers 2..NUM_REGS-1 are RW; their reset value is 0.
- Write channel FSM states:
  - IDLE: awready=1, wready=1.
  - HAVE_ADDR: AW captured; wready=1, awready=0.
  - HAVE_DATA: W captured; awready=1, wready=0.
  - RESP: bvalid=1, both readies 0.
- AW and W may complete in either order or in the same cycle.
- At the edge where the second of AW/W completes:
  - Selected RW register: bytes with wstrb[k]=1 are updated; the others are held.
  - wr_pulse_o[idx] is set for one cycle.
  - FSM moves to RESP.
- RESP → IDLE on bvalid & bready.
- Write response codes:
  - Index ≥ NUM_REGS: SLVERR (2'b10), no update, no pulse.
  - Index 0 or 1: SLVERR, no update, no pulse.
  - Otherwise: OKAY (2'b00), even when wstrb = 0; the pulse still fires.
- Read channel FSM states:
  - IDLE: arready=1.
  - RESP: rvalid=1, arready=0.
- AR handshake registers rdata/rresp. RESP → IDLE on rvalid & rready.
- Out-of-range read: rdata=0, rresp=SLVERR.
- Address bits [1:0] are ignored (no alignment error).
- Read and write channels are fully independent and may complete in the same cycle.

## Timing
- Reset values: all readies 0 during rst and 1 in the first cycle after rst deasserts; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse_o=0, RW registers 0.
- Write latency: bvalid, the register update on regs_o and wr_pulse_o all become visible in the cycle after the final AW/W handshake.
- Read latency: rvalid is visible in the cycle after the AR handshake. Throughput is one read per 2 cycles when rready is held at 1.
- Backpressure: bvalid/rvalid and their data and response stay stable until accepted; no new transaction is accepted meanwhile.
- Same-edge read and write to the same register: the read returns the pre-write value.
- rst asserted mid-transaction: captured address/data are discarded, pending responses are dropped, and RW registers clear. The master must reissue.

## Structure
- Package axi_lite_regbank_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Register indices IDX_CORE_ID=0 and IDX_DATE=1, plus their byte addresses.
  - Write FSM enum wr_state_t {IDLE, HAVE_ADDR, HAVE_DATA, RESP} and read FSM enum rd_state_t {IDLE, RESP}.
  - The existing TB constants (clock period, reset count).
- One natural sub-module: axi_lite_strb_merge, a combinational per-byte merge of old data, wdata and wstrb, reusable by other slaves. Everything else stays in the top module.

## Test plan
- Reset, then read 0x00 and 0x04 → rdata = CORE_ID and DATE, rresp=OKAY, each rvalid one cycle after AR.
- Send W before AW: wdata=0xDEADBEEF, wstrb=4'b1111 to 0x08 → bresp=OKAY, regs_o[2]=0xDEADBEEF, wr_pulse_o[2] high for one cycle; readback matches.
- Partial strobe: wdata=0x11223344, wstrb=4'b0101 on register 3 (value 0xFFFFFFFF) → 0xFF22FF44.
- Write to 0x00 and to 0x7C with NUM_REGS=8 → bresp=SLVERR, no register change, no pulse; read 0x7C → rdata=0, SLVERR.
- Hold bready=0 for 5 cycles and rready=0 for 5 cycles → bvalid/rvalid and their data stay stable, awready/wready/arready stay 0, and the responses complete when ready rises.
- Same-cycle AR and AW+W to 0x08 (old 0x0, new 0x5) → rdata=0x0, then readback=0x5. Assert rst between AW and W → no update, bvalid never rises.
